// File: rtl/core_bus_ram_if.sv
// Core memory bus: the arbiter-side initiator drives the request fields, the RAM answers.
interface core_bus_ram_if;
  logic        bus_start;
  logic        bus_write;
  logic [29:0] bus_addr;
  logic [31:0] bus_data_wr;
  logic        bus_ready;
  logic [31:0] bus_data_rd;
  logic        bus_fault;

  modport master (
    output bus_start,
    output bus_write,
    output bus_addr,
    output bus_data_wr,
    input  bus_ready,
    input  bus_data_rd,
    input  bus_fault
  );

  modport slave (
    input  bus_start,
    input  bus_write,
    input  bus_addr,
    input  bus_data_wr,
    output bus_ready,
    output bus_data_rd,
    output bus_fault
  );
endinterface

// File: rtl/core_bus_ram.sv
// Single-port 32-bit word RAM acting as the responder on the core memory bus.
// Each accepted request completes with a one-cycle bus_ready pulse WAIT_CYCLES+1 cycles later.
// Optional feature macro: CORE_BUS_RAM_FAULT_EN enables the address window check and bus_fault.
module core_bus_ram #(
  parameter logic [29:0] ADDR_BASE   = 30'h0,
  parameter int unsigned DEPTH_LOG2  = 12,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic           clk,
  input logic           rst,
  core_bus_ram_if.slave bus
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned IdxW  = DEPTH_LOG2;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ld;
  logic        commit;

  logic [29:0] addr_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  // Array is not reset; the initialiser only gives simulation a known all-zero start.
  logic [31:0] mem_q [Depth] = '{default: '0};

  // Request seen at the edge entering RESP: live bus fields when accepted with zero wait
  // states, otherwise the copy latched at accept time.
  logic            use_bus;
  logic [29:0]     c_addr;
  logic            c_write;
  logic [31:0]     c_wdata;
  logic [IdxW-1:0] c_idx;
  logic            c_in_range;

`ifdef CORE_BUS_RAM_FAULT_EN
  logic [29:0] c_off;
  logic        fault_q;
`endif

  // Select request source and decode the array index / window hit.
  always_comb begin
    use_bus = (state_q != StWait);
    c_addr  = use_bus ? bus.bus_addr    : addr_q;
    c_write = use_bus ? bus.bus_write   : write_q;
    c_wdata = use_bus ? bus.bus_data_wr : wdata_q;
    c_idx   = IdxW'(c_addr - ADDR_BASE);
`ifdef CORE_BUS_RAM_FAULT_EN
    // Unsigned offset wraps high for addresses below the base, so one test covers both ends.
    c_off      = c_addr - ADDR_BASE;
    c_in_range = ((c_off >> DEPTH_LOG2) == '0);
`else
    c_in_range = 1'b1;
`endif
  end

  // Next-state logic; a start during WAIT is deliberately ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_ld  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      StIdle, StResp: begin
        if (bus.bus_start) begin
          req_ld = 1'b1;
          cnt_d  = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = StResp;
          commit  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latch the request fields at accept time.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else if (req_ld) begin
      addr_q  <= bus.bus_addr;
      write_q <= bus.bus_write;
      wdata_q <= bus.bus_data_wr;
    end
  end

  // Array write at the edge entering RESP; reset at that edge aborts the commit.
  always_ff @(posedge clk) begin
    if (!rst && commit && c_write && c_in_range) begin
      mem_q[c_idx] <= c_wdata;
    end
  end

  // Response data captured at the same edge; writes and faulting reads return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (commit) begin
      rdata_q <= (!c_write && c_in_range) ? mem_q[c_idx] : 32'h0;
    end
  end

`ifdef CORE_BUS_RAM_FAULT_EN
  // Window-miss flag for the pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (commit) begin
      fault_q <= !c_in_range;
    end
  end
`endif

  // Outputs are forced to zero outside the RESP cycle.
  always_comb begin
    bus.bus_ready   = (state_q == StResp);
    bus.bus_data_rd = bus.bus_ready ? rdata_q : 32'h0;
`ifdef CORE_BUS_RAM_FAULT_EN
    bus.bus_fault   = bus.bus_ready & fault_q;
`else
    bus.bus_fault   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_core_bus_ram.sv
// Directed bench for core_bus_ram: one instance with two wait states, one with none.
module tb_core_bus_ram;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  core_bus_ram_if b2 ();
  core_bus_ram_if b0 ();

  core_bus_ram #(
    .ADDR_BASE  (30'h100),
    .DEPTH_LOG2 (4),
    .WAIT_CYCLES(2)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(b2.slave)
  );

  core_bus_ram #(
    .ADDR_BASE  (30'h100),
    .DEPTH_LOG2 (4),
    .WAIT_CYCLES(0)
  ) u_dut0 (
    .clk(clk),
    .rst(rst),
    .bus(b0.slave)
  );

  typedef struct {
    logic        wr;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[8];
  int   n_pass  = 0;
  int   n_total = 0;

`ifdef CORE_BUS_RAM_FAULT_EN
  localparam bit FaultEn = 1'b1;
`else
  localparam bit FaultEn = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction on the two-wait-state instance.
  task automatic run_vec(input vec_t v, input string tag);
    b2.bus_start   = 1'b1;
    b2.bus_write   = v.wr;
    b2.bus_addr    = v.addr;
    b2.bus_data_wr = v.wdata;
    tick();
    b2.bus_start = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      chk({tag, " ready_early"}, {31'b0, b2.bus_ready}, 32'd0);
      tick();
    end
    chk({tag, " ready"}, {31'b0, b2.bus_ready}, 32'd1);
    chk({tag, " data"}, b2.bus_data_rd, v.exp_rd);
    chk({tag, " fault"}, {31'b0, b2.bus_fault}, {31'b0, v.exp_fault});
    tick();
    chk({tag, " ready_after"}, {31'b0, b2.bus_ready}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 30'h105, 32'hDEADBEEF, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 30'h105, 32'h0, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 30'h10F, 32'h0000CAFE, 32'h0, 1'b0};
    vecs[3] = '{1'b0, 30'h10F, 32'h0, 32'h0000CAFE, 1'b0};
    vecs[4] = '{1'b0, 30'h100, 32'h0, 32'h0, 1'b0};
    // Out-of-window write: faults and is dropped, or aliases onto entry 0.
    vecs[5] = '{1'b1, 30'h110, 32'hFFFFFFFF, 32'h0, FaultEn};
    vecs[6] = '{1'b0, 30'h100, 32'h0, FaultEn ? 32'h0 : 32'hFFFFFFFF, 1'b0};
    // Below the base: faults, or aliases onto entry 15.
    vecs[7] = '{1'b0, 30'h0FF, 32'h0, FaultEn ? 32'h0 : 32'h0000CAFE, FaultEn};

    b2.bus_start = 1'b0; b2.bus_write = 1'b0; b2.bus_addr = '0; b2.bus_data_wr = '0;
    b0.bus_start = 1'b0; b0.bus_write = 1'b0; b0.bus_addr = '0; b0.bus_data_wr = '0;
    rst = 1'b1;
    tick();
    tick();
    chk("reset ready", {31'b0, b2.bus_ready}, 32'd0);
    chk("reset data", b2.bus_data_rd, 32'h0);
    chk("reset fault", {31'b0, b2.bus_fault}, 32'd0);
    chk("reset ready0", {31'b0, b0.bus_ready}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back read-after-write: read issued in the write's RESP cycle.
    b2.bus_start = 1'b1; b2.bus_write = 1'b1; b2.bus_addr = 30'h101; b2.bus_data_wr = 32'h12345678;
    tick();
    b2.bus_start = 1'b0;
    tick();
    tick();
    chk("raw wr ready", {31'b0, b2.bus_ready}, 32'd1);
    chk("raw wr data", b2.bus_data_rd, 32'h0);
    b2.bus_start = 1'b1; b2.bus_write = 1'b0; b2.bus_addr = 30'h101;
    tick();
    b2.bus_start = 1'b0;
    chk("raw t4 ready", {31'b0, b2.bus_ready}, 32'd0);
    tick();
    chk("raw t5 ready", {31'b0, b2.bus_ready}, 32'd0);
    tick();
    chk("raw rd ready", {31'b0, b2.bus_ready}, 32'd1);
    chk("raw rd data", b2.bus_data_rd, 32'h12345678);
    tick();

    // Protocol violation: second start during WAIT must be ignored.
    b2.bus_start = 1'b1; b2.bus_write = 1'b0; b2.bus_addr = 30'h105;
    tick();
    chk("viol t1 ready", {31'b0, b2.bus_ready}, 32'd0);
    b2.bus_addr = 30'h10F;
    tick();
    b2.bus_start = 1'b0;
    chk("viol t2 ready", {31'b0, b2.bus_ready}, 32'd0);
    tick();
    chk("viol ready", {31'b0, b2.bus_ready}, 32'd1);
    chk("viol data", b2.bus_data_rd, 32'hDEADBEEF);
    for (int c = 4; c <= 6; c++) begin
      tick();
      chk($sformatf("viol t%0d no_ready", c), {31'b0, b2.bus_ready}, 32'd0);
    end

    // Reset during WAIT of a write: no response and no commit.
    b2.bus_start = 1'b1; b2.bus_write = 1'b1; b2.bus_addr = 30'h102; b2.bus_data_wr = 32'hAAAA5555;
    tick();
    b2.bus_start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      chk($sformatf("rstmid t%0d no_ready", c), {31'b0, b2.bus_ready}, 32'd0);
      tick();
    end
    run_vec('{1'b0, 30'h102, 32'h0, 32'h0, 1'b0}, "rstmid read");

    // Reset coinciding with start: request dropped.
    rst = 1'b1;
    b2.bus_start = 1'b1; b2.bus_write = 1'b1; b2.bus_addr = 30'h103; b2.bus_data_wr = 32'h11111111;
    tick();
    rst = 1'b0;
    b2.bus_start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("rststart t%0d no_ready", c), {31'b0, b2.bus_ready}, 32'd0);
      tick();
    end
    run_vec('{1'b0, 30'h103, 32'h0, 32'h0, 1'b0}, "rststart read");

    // Zero wait states: writes then reads issued every cycle, response every cycle.
    for (int i = 0; i < 4; i++) begin
      b0.bus_start = 1'b1; b0.bus_write = 1'b1;
      b0.bus_addr = 30'h100 + 30'(i); b0.bus_data_wr = 32'hA0 + 32'(i);
      tick();
      chk($sformatf("zw wr%0d ready", i), {31'b0, b0.bus_ready}, 32'd1);
      chk($sformatf("zw wr%0d data", i), b0.bus_data_rd, 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      b0.bus_start = 1'b1; b0.bus_write = 1'b0; b0.bus_addr = 30'h100 + 30'(i);
      tick();
      chk($sformatf("zw rd%0d ready", i), {31'b0, b0.bus_ready}, 32'd1);
      chk($sformatf("zw rd%0d data", i), b0.bus_data_rd, 32'hA0 + 32'(i));
    end
    b0.bus_start = 1'b0;
    tick();
    chk("zw idle ready", {31'b0, b0.bus_ready}, 32'd0);
    chk("zw idle data", b0.bus_data_rd, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/core_bus_ram.md
# core_bus_ram

Single-port word RAM that acts as the responder end of the core memory bus. The core MMU arbiter is the only initiator: it issues `bus_start`/`bus_addr`/`bus_write`/`bus_data_wr`, and this block answers with `bus_ready`/`bus_data_rd` after a fixed, parameterised number of wait states. The block sits behind the bus arbiter as on-chip boot/scratch memory and serves as the reference responder model for bus timing.

## Interface
- `ADDR_BASE`, default 30'h0: word address of entry 0; must be aligned to 2**`DEPTH_LOG2`.
- `DEPTH_LOG2`, default 12: log2 of RAM depth in 32-bit words.
- `WAIT_CYCLES`, default 1: extra cycles between accept and `bus_ready`; allowed range 0..15.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `bus_start` in 1: single-cycle request strobe.
- `bus_write` in 1: 1 = write, 0 = read; sampled with `bus_start`.
- `bus_addr` in 30 (ptr): word address; sampled with `bus_start`.
- `bus_data_wr` in 32 (word): write data; sampled with `bus_start`.
- `bus_ready` out 1: single-cycle completion pulse.
- `bus_data_rd` out 32 (word): read data, valid only while `bus_ready`=1.
- `bus_fault` out 1: out-of-window access flag, valid only while `bus_ready`=1.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `bus_start`=1 latches addr/write/data and loads the wait counter with `WAIT_CYCLES`. The next state is WAIT if `WAIT_CYCLES`>0, else RESP.
- WAIT: the counter decrements each cycle. Counter at 1 → RESP next.
- RESP: `bus_ready`=1 for exactly one cycle.
  - `bus_start`=1 in RESP is accepted as a back-to-back request, handled exactly as in IDLE.
  - Otherwise the next state is IDLE.
- `bus_start` in WAIT is a protocol violation. The block ignores it: the latched request and counter are unchanged and no second response is generated.
- Write commit: the array is written at the clock edge entering RESP. Reads latch array data at that same edge.
- Index is `bus_addr - ADDR_BASE` truncated to `DEPTH_LOG2` bits.
- Outputs outside RESP: `bus_ready`=0, `bus_data_rd`=0, `bus_fault`=0. For a write, `bus_data_rd`=0 also during RESP.
- The RAM array is not cleared by reset. It initialises to zero for simulation only.

## Timing
- Request accepted in cycle T → `bus_ready` in cycle T+1+`WAIT_CYCLES`.
- Sustained throughput with back-to-back starts issued in each RESP cycle: one access per `WAIT_CYCLES`+1 cycles.
- Read-after-write: a read started in the RESP cycle of a write to the same address returns the new data.
- Reset values: state IDLE, counter 0, `bus_ready`=0, `bus_data_rd`=0, `bus_fault`=0.
- `rst` mid-transaction, in WAIT or RESP:
  - The transaction is aborted and no `bus_ready` follows.
  - A write that has not reached RESP is not committed.
  - A write whose RESP cycle coincides with `rst` is already committed.
- `rst` together with `bus_start` in the same cycle: `rst` wins and the request is dropped.

## Configuration
- `CORE_BUS_RAM_FAULT_EN` defined:
  - An address outside [`ADDR_BASE`, `ADDR_BASE`+2**`DEPTH_LOG2`) still completes with normal latency.
  - In that RESP cycle `bus_fault`=1 and `bus_data_rd`=0.
  - A write to such an address is dropped and the array is unchanged.
- `CORE_BUS_RAM_FAULT_EN` undefined:
  - No range check; all addresses alias modulo depth.
  - `bus_fault` is tied to 0. The port remains present.

## Test plan
Parameters unless stated: `ADDR_BASE`=30'h100, `DEPTH_LOG2`=4, `WAIT_CYCLES`=2.
- Write then read: write 32'hDEADBEEF to 30'h105 at T → `bus_ready` at T+3. Read 30'h105 at T+5 → `bus_ready` at T+8 with `bus_data_rd`=32'hDEADBEEF and `bus_fault`=0.
- Back-to-back read-after-write: write 32'h12345678 to 30'h101 at T, then read 30'h101 in RESP cycle T+3 → ready at T+6 with data 32'h12345678. No idle cycle between the two transactions.
- Zero wait: `WAIT_CYCLES`=0, continuous starts every cycle reading 30'h100..30'h103 → `bus_ready` every cycle starting T+1, data in order.
- Violation: start at T, second start at T+1 (WAIT) → exactly one `bus_ready`, at T+3, carrying the first request's data.
- Reset mid-op: write 32'hAAAA5555 to 30'h102 at T, `rst` at T+1 → no `bus_ready`. A later read of 30'h102 returns the prior value 0.
- Fault: with `CORE_BUS_RAM_FAULT_EN`, write 32'hFFFFFFFF to 30'h110 → ready with `bus_fault`=1, and 30'h100 still reads 0. Without the macro, the same write makes a read of 30'h100 return 32'hFFFFFFFF and `bus_fault` stays 0.
